multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multicycle MIPS core, upstream of the datapath. It takes op/funct from the instruction register and zero from the ALU. Each cycle it drives the datapath's enables and mux selects: PC, IR, register file, memory, the ALU source muxes and the ALU operation. It is a Moore main FSM plus a combinational ALU decoder; its outputs connect directly to the datapath control inputs.

Parameters:
STATE_W, 4, width of the state register (must be at least 4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag, same cycle
pcen  out  1  PC register enable
memwrite  out  1  memory write enable
irwrite  out  1  instruction register enable
regwrite  out  1  register file write enable
alusrca  out  1  0=PC, 1=A
iord  out  1  0=PC address, 1=ALUOut address
memtoreg  out  1  0=ALUOut, 1=Data
regdst  out  1  0=rt, 1=rd
alusrcb  out  2  00=B, 01=4, 10=signimm, 11=signimm<<2
pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
illegal  out  1  one-cycle pulse in DECODE for an unsupported op

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low: while reset==0 at a rising edge, state <= FETCH.
- Outputs during reset: while reset==0, pcen, memwrite, irwrite, regwrite and illegal are forced to 0 combinationally. All other outputs take their FETCH values (alusrcb=01, rest 0, alucontrol=010).
- Reset mid-instruction aborts it; no partial write completes after the reset edge.
- Output decode: Moore, decoded from state only. Exception: pcen = pcwrite | (branch & zero).
- Default for every control signal not listed in a state: 0. aluop defaults to 00.
- States and asserted controls:
  FETCH: irwrite, pcwrite, alusrcb=01, aluop=00. Next DECODE.
  DECODE: alusrcb=11, aluop=00. Next by op:
    000000 -> EXECUTE
    100011 (lw) or 101011 (sw) -> MEMADR
    000100 (beq) -> BEQEX
    001000 (addi) -> ADDIEX
    000010 (j) -> JEX
    other -> FETCH, with illegal=1 (instruction acts as a NOP)
  MEMADR: alusrca, alusrcb=10. lw -> MEMRD; sw -> MEMWR.
  MEMRD: iord. Next MEMWB.
  MEMWB: memtoreg, regwrite. Next FETCH.
  MEMWR: iord, memwrite. Next FETCH.
  EXECUTE: alusrca, aluop=10. Next ALUWB.
  ALUWB: regdst, regwrite. Next FETCH.
  BEQEX: alusrca, aluop=01, pcsrc=01, branch. Next FETCH.
  ADDIEX: alusrca, alusrcb=10. Next ADDIWB.
  ADDIWB: regwrite. Next FETCH.
  JEX: pcsrc=10, pcwrite. Next FETCH.
- Unused state encodings -> FETCH on the next edge, with all write enables 0.
- ALU decoder:
  aluop 00 -> 010; 01 -> 110; 11 -> 010.
  aluop 10 -> decode funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
- Latency in cycles: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.

Optional Feature:
BNE_EN
- Defined: op 000101 (bne) goes from DECODE to BNEEX. BNEEX drives the same controls as BEQEX, with bnebranch replacing branch. pcen additionally includes (bnebranch & ~zero). bne takes 3 cycles.
- Undefined: op 000101 is illegal (illegal pulse, NOP). BNEEX has no encoding.

Decomposition:
- Package mc_ctrl_pkg: state enum (STATE_W bits), opcode constants, funct constants, aluop and alucontrol constants.
- One sub-module, alu_decoder: combinational, inputs aluop[1:0] and funct[5:0], output alucontrol[2:0]. Main FSM lives in multicycle_ctrl.

Test Plan:
- Reset and FETCH: hold reset=0 for 2 cycles, then release -> all enables 0 during reset. First post-reset cycle is FETCH: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw then sw: op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5. op=101011 -> memwrite=1 and iord=1 in cycle 4 only.
- R-type sweep: op=0 with funct 100000, 100010, 100100, 100101, 101010 -> in EXECUTE, alucontrol = 010, 110, 000, 001, 111 respectively. ALUWB has regdst=1, regwrite=1.
- beq: op=000100 with zero=1 -> pcen=1, pcsrc=01 in BEQEX. With zero=0 -> pcen=0. Next state FETCH in both cases.
- j and illegal: op=000010 -> JEX with pcen=1, pcsrc=10. op=111111 -> illegal=1 for exactly one cycle, then FETCH, with no write enable asserted.
- Reset mid-instruction: reset=0 in MEMWR -> memwrite=0 immediately, state=FETCH after the edge. With BNE_EN, op=000101 and zero=0 -> pcen=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// BNE_EN adds the bne opcode and its BNEEX state.
package mc_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef BNE_EN
    , BNEEX = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       bnebranch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  // Moore decode of the control word for one state; anything unlisted stays 0.
  function automatic ctl_t stateCtl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
`ifdef BNE_EN
      BNEEX: begin
        c.alusrca   = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pcsrc     = 2'b01;
        c.bnebranch = 1'b1;
      end
`endif
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps aluop and funct onto the ALU operation code.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core with registered control word.
// Define BNE_EN to add the bne instruction.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  logic [STATE_W-1:0] state;
  state_t cur, nxt;
  ctl_t   ctlq, ctl;
  logic   stateok, opok, wren;

  always_comb begin
    cur     = state_t'(state[STATE_BITS-1:0]);
    stateok = 1'b0;
    case (cur)
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB,
      BEQEX, ADDIEX, ADDIWB, JEX
`ifdef BNE_EN
      , BNEEX
`endif
      : stateok = ((state >> STATE_BITS) == '0);
      default: stateok = 1'b0;
    endcase
  end

  always_comb begin
    opok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
`ifdef BNE_EN
      , OP_BNE
`endif
      : opok = 1'b1;
      default: opok = 1'b0;
    endcase
  end

  // Unsupported opcodes fall straight back to FETCH and behave as a NOP.
  always_comb begin
    nxt = FETCH;
    if (stateok) begin
      case (cur)
        FETCH: nxt = DECODE;
        DECODE: begin
          case (op)
            OP_RTYPE:     nxt = EXECUTE;
            OP_LW, OP_SW: nxt = MEMADR;
            OP_BEQ:       nxt = BEQEX;
            OP_ADDI:      nxt = ADDIEX;
            OP_J:         nxt = JEX;
`ifdef BNE_EN
            OP_BNE:       nxt = BNEEX;
`endif
            default:      nxt = FETCH;
          endcase
        end
        MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   nxt = MEMWB;
        EXECUTE: nxt = ALUWB;
        ADDIEX:  nxt = ADDIWB;
        default: nxt = FETCH;
      endcase
    end
  end

  // The control word is registered alongside the state so outputs come from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= STATE_W'(FETCH);
      ctlq  <= stateCtl(FETCH);
    end else begin
      state <= STATE_W'(nxt);
      ctlq  <= stateCtl(nxt);
    end
  end

  always_comb begin
    ctl      = reset ? ctlq : stateCtl(FETCH);
    wren     = reset & stateok;
    pcen     = wren & (ctl.pcwrite | (ctl.branch & zero) | (ctl.bnebranch & ~zero));
    memwrite = wren & ctl.memwrite;
    irwrite  = wren & ctl.irwrite;
    regwrite = wren & ctl.regwrite;
    illegal  = wren & (cur == DECODE) & ~opok;
    alusrca  = ctl.alusrca;
    iord     = ctl.iord;
    memtoreg = ctl.memtoreg;
    regdst   = ctl.regdst;
    alusrcb  = ctl.alusrcb;
    pcsrc    = ctl.pcsrc;
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; outputs are compared as one packed control vector.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int assertions = 0;
  int failures   = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] outVec;
  assign outVec = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                   alusrcb, pcsrc, alucontrol, illegal};

  function automatic logic [15:0] cv(input logic pe, mw, irw, rw, asa, io, m2r, rd,
                                     input logic [1:0] asb, ps, input logic [2:0] ac,
                                     input logic ill);
    return {pe, mw, irw, rw, asa, io, m2r, rd, asb, ps, ac, ill};
  endfunction

  // Hand-derived control vectors, one per state.
  logic [15:0] vReset, vFetch, vDecode, vDecodeIll, vMemAdr, vMemRd, vMemWb, vMemWr;
  logic [15:0] vAluWb, vBranchT, vBranchN, vAddiEx, vAddiWb, vJex;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  task automatic stepCheck(input string tag, input logic [15:0] exp);
    @(negedge clk);
    checkOutput(tag, outVec, exp);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rFunct [5];
  logic [2:0] rAlu   [5];

  initial begin
    vReset     = cv(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    vFetch     = cv(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    vDecode    = cv(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    vDecodeIll = cv(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1);
    vMemAdr    = cv(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010,0);
    vMemRd     = cv(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0);
    vMemWb     = cv(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0);
    vMemWr     = cv(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010,0);
    vAluWb     = cv(0,0,0,1,0,0,0,1,2'b00,2'b00,3'b010,0);
    vBranchT   = cv(1,0,0,0,1,0,0,0,2'b00,2'b01,3'b110,0);
    vBranchN   = cv(0,0,0,0,1,0,0,0,2'b00,2'b01,3'b110,0);
    vAddiEx    = cv(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010,0);
    vAddiWb    = cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010,0);
    vJex       = cv(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0);
    rFunct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rAlu   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    reset = 1'b0;
    applyStimulus(6'b100011, 6'b0, 1'b0);
    @(posedge clk);
    #1;
    stepCheck("reset_cycle1", vReset);
    stepCheck("reset_cycle2", vReset);
    reset = 1'b1;

    stepCheck("lw_fetch", vFetch);
    stepCheck("lw_decode", vDecode);
    stepCheck("lw_memadr", vMemAdr);
    stepCheck("lw_memrd", vMemRd);
    stepCheck("lw_memwb", vMemWb);

    applyStimulus(6'b101011, 6'b0, 1'b0);
    stepCheck("sw_fetch", vFetch);
    stepCheck("sw_decode", vDecode);
    stepCheck("sw_memadr", vMemAdr);
    stepCheck("sw_memwr", vMemWr);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(6'b000000, rFunct[i], 1'b0);
      stepCheck("r_fetch", vFetch);
      stepCheck("r_decode", vDecode);
      stepCheck("r_execute", cv(0,0,0,0,1,0,0,0,2'b00,2'b00,rAlu[i],0));
      stepCheck("r_aluwb", vAluWb);
    end

    applyStimulus(6'b000100, 6'b0, 1'b1);
    stepCheck("beq_t_fetch", vFetch);
    stepCheck("beq_t_decode", vDecode);
    stepCheck("beq_taken", vBranchT);
    applyStimulus(6'b000100, 6'b0, 1'b0);
    stepCheck("beq_n_fetch", vFetch);
    stepCheck("beq_n_decode", vDecode);
    stepCheck("beq_not_taken", vBranchN);

    applyStimulus(6'b001000, 6'b0, 1'b0);
    stepCheck("addi_fetch", vFetch);
    stepCheck("addi_decode", vDecode);
    stepCheck("addi_ex", vAddiEx);
    stepCheck("addi_wb", vAddiWb);

    applyStimulus(6'b000010, 6'b0, 1'b0);
    stepCheck("j_fetch", vFetch);
    stepCheck("j_decode", vDecode);
    stepCheck("j_jex", vJex);

    applyStimulus(6'b111111, 6'b0, 1'b0);
    stepCheck("ill_fetch", vFetch);
    stepCheck("ill_decode", vDecodeIll);
    stepCheck("ill_back_to_fetch", vFetch);
    applyStimulus(6'b000010, 6'b0, 1'b0);
    stepCheck("after_ill_decode", vDecode);
    stepCheck("after_ill_jex", vJex);

`ifdef BNE_EN
    applyStimulus(6'b000101, 6'b0, 1'b0);
    stepCheck("bne_t_fetch", vFetch);
    stepCheck("bne_t_decode", vDecode);
    stepCheck("bne_taken", vBranchT);
    applyStimulus(6'b000101, 6'b0, 1'b1);
    stepCheck("bne_n_fetch", vFetch);
    stepCheck("bne_n_decode", vDecode);
    stepCheck("bne_not_taken", vBranchN);
`else
    applyStimulus(6'b000101, 6'b0, 1'b0);
    stepCheck("bne_ill_fetch", vFetch);
    stepCheck("bne_ill_decode", vDecodeIll);
`endif

    applyStimulus(6'b101011, 6'b0, 1'b0);
    stepCheck("mid_fetch", vFetch);
    stepCheck("mid_decode", vDecode);
    stepCheck("mid_memadr", vMemAdr);
    #1;
    checkOutput("mid_memwr_active", outVec, vMemWr);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_forced", outVec, vReset);
    @(posedge clk);
    #1;
    reset = 1'b1;
    stepCheck("mid_after_fetch", vFetch);
    stepCheck("mid_after_decode", vDecode);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
